// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC and the IF/ID pipeline register, with
// stall (pc_hold) and redirect (branch_taken) handling plus saturating event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             pc_hold,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [31:0]      pc_plus4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // 32-bit modulo add: 32'hFFFF_FFFC wraps to zero.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (branch_taken) begin
            // Redirect wins over a simultaneous stall; the squashed slot becomes a NOP bubble.
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            flush_d = sat_inc(flush_q);
        end else if (pc_hold) begin
            stall_d = sat_inc(stall_q);
        end else begin
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected post-edge state,
// a monitor pops and compares after each rising edge. Two instances cover default and wrap/saturation params.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h1300_0000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid, input logic [31:0] stall, input logic [31:0] flush);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pc4 = pc4; e.valid = valid; e.stall = stall; e.flush = flush;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Instance 0: default parameters
    logic        rn0 = 1'b0, h0 = 1'b0, b0 = 1'b0;
    logic [31:0] t0 = 32'h0;
    logic [31:0] addr0, instr0, pc40;
    logic        v0;
    logic [15:0] sc0, fc0;
    logic [31:0] rdata0;
    assign rdata0 = memw(addr0);

    fetch_stage dut0 (
        .CLOCK(CLOCK), .RESET_N(rn0), .pc_hold(h0), .branch_taken(b0), .branch_target(t0),
        .imem_rdata(rdata0), .imem_addr(addr0), .if_id_instr(instr0), .if_id_pc4(pc40),
        .if_id_valid(v0), .stall_count(sc0), .flush_count(fc0)
    );

    // Instance 1: PC wrap and 2-bit counter saturation
    logic        rn1 = 1'b0, h1 = 1'b0, b1 = 1'b0;
    logic [31:0] t1 = 32'h0;
    logic [31:0] addr1, instr1, pc41;
    logic        v1;
    logic [1:0]  sc1, fc1;
    logic [31:0] rdata1;
    assign rdata1 = memw(addr1);

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut1 (
        .CLOCK(CLOCK), .RESET_N(rn1), .pc_hold(h1), .branch_taken(b1), .branch_target(t1),
        .imem_rdata(rdata1), .imem_addr(addr1), .if_id_instr(instr1), .if_id_pc4(pc41),
        .if_id_valid(v1), .stall_count(sc1), .flush_count(fc1)
    );

    task automatic drv0(input logic rn, input logic h, input logic b, input logic [31:0] tgt, input exp_t e);
        @(negedge CLOCK);
        rn0 = rn; h0 = h; b0 = b; t0 = tgt;
        q0.push_back(e);
    endtask

    task automatic drv1(input logic rn, input logic h, input logic b, input logic [31:0] tgt, input exp_t e);
        @(negedge CLOCK);
        rn1 = rn; h1 = h; b1 = b; t1 = tgt;
        q1.push_back(e);
    endtask

    // Monitor: compares each expected entry one time unit after the edge it describes.
    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("d0.imem_addr", addr0, e.pc);
                chk("d0.if_id_instr", instr0, e.instr);
                chk("d0.if_id_pc4", pc40, e.pc4);
                chk("d0.if_id_valid", {31'b0, v0}, {31'b0, e.valid});
                chk("d0.stall_count", {16'b0, sc0}, e.stall);
                chk("d0.flush_count", {16'b0, fc0}, e.flush);
            end
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("d1.imem_addr", addr1, e.pc);
                chk("d1.if_id_instr", instr1, e.instr);
                chk("d1.if_id_pc4", pc41, e.pc4);
                chk("d1.if_id_valid", {31'b0, v1}, {31'b0, e.valid});
                chk("d1.stall_count", {30'b0, sc1}, e.stall);
                chk("d1.flush_count", {30'b0, fc1}, e.flush);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then free-running fetch
        drv0(0, 0, 0, 0, mk(32'h0, 32'h0, 32'h0, 0, 0, 0));
        drv0(0, 0, 0, 0, mk(32'h0, 32'h0, 32'h0, 0, 0, 0));
        drv0(1, 0, 0, 0, mk(32'h4, memw(32'h0), 32'h4, 1, 0, 0));
        drv0(1, 0, 0, 0, mk(32'h8, memw(32'h4), 32'h8, 1, 0, 0));
        // Hold two edges at PC=8, then release
        drv0(1, 1, 0, 0, mk(32'h8, memw(32'h4), 32'h8, 1, 1, 0));
        drv0(1, 1, 0, 0, mk(32'h8, memw(32'h4), 32'h8, 1, 2, 0));
        drv0(1, 0, 0, 0, mk(32'hC, memw(32'h8), 32'hC, 1, 2, 0));
        drv0(1, 0, 0, 0, mk(32'h10, memw(32'hC), 32'h10, 1, 2, 0));
        // Redirect at PC=16 to an unaligned target
        drv0(1, 0, 1, 32'h0000_0103, mk(32'h100, 32'h0, 32'h0, 0, 2, 1));
        drv0(1, 0, 0, 0, mk(32'h104, memw(32'h100), 32'h104, 1, 2, 1));
        // Redirect with simultaneous hold
        drv0(1, 1, 1, 32'h40, mk(32'h40, 32'h0, 32'h0, 0, 2, 2));
        drv0(1, 0, 0, 0, mk(32'h44, memw(32'h40), 32'h44, 1, 2, 2));
        // Build stall_count to 5, then reset mid-stall and mid-redirect
        drv0(1, 1, 0, 0, mk(32'h44, memw(32'h40), 32'h44, 1, 3, 2));
        drv0(1, 1, 0, 0, mk(32'h44, memw(32'h40), 32'h44, 1, 4, 2));
        drv0(1, 1, 0, 0, mk(32'h44, memw(32'h40), 32'h44, 1, 5, 2));
        drv0(0, 1, 1, 32'h80, mk(32'h0, 32'h0, 32'h0, 0, 0, 0));
        drv0(1, 0, 0, 0, mk(32'h4, memw(32'h0), 32'h4, 1, 0, 0));

        // Instance 1: wrap from 32'hFFFF_FFFC and counter saturation
        drv1(0, 1, 1, 32'h20, mk(32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0));
        drv1(1, 0, 0, 0, mk(32'h0, memw(32'hFFFF_FFFC), 32'h0, 1, 0, 0));
        drv1(1, 1, 0, 0, mk(32'h0, memw(32'hFFFF_FFFC), 32'h0, 1, 1, 0));
        drv1(1, 1, 0, 0, mk(32'h0, memw(32'hFFFF_FFFC), 32'h0, 1, 2, 0));
        drv1(1, 1, 0, 0, mk(32'h0, memw(32'hFFFF_FFFC), 32'h0, 1, 3, 0));
        drv1(1, 1, 0, 0, mk(32'h0, memw(32'hFFFF_FFFC), 32'h0, 1, 3, 0));
        drv1(1, 1, 0, 0, mk(32'h0, memw(32'hFFFF_FFFC), 32'h0, 1, 3, 0));
        drv1(1, 0, 1, 32'h20, mk(32'h20, 32'h0, 32'h0, 0, 3, 1));
        drv1(1, 0, 1, 32'h24, mk(32'h24, 32'h0, 32'h0, 0, 3, 2));
        drv1(1, 0, 1, 32'h28, mk(32'h28, 32'h0, 32'h0, 0, 3, 3));
        drv1(1, 0, 1, 32'h2C, mk(32'h2C, 32'h0, 32'h0, 0, 3, 3));
        drv1(1, 0, 0, 0, mk(32'h30, memw(32'h2C), 32'h30, 1, 3, 3));

        // Drain: every pushed expectation must have been consumed
        repeat (3) @(negedge CLOCK);
        chk("d0.queue_drained", q0.size(), 32'd0);
        chk("d1.queue_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each event counter.
REQ-003 The block SHALL use a single clock, CLOCK; reset is synchronous and active-low, RESET_N.
REQ-004 CLOCK  input  1  rising-edge clock for all state.
REQ-005 RESET_N  input  1  synchronous active-low reset.
REQ-006 pc_hold  input  1  stall request from the hazard detection unit; 1 = freeze PC and the IF/ID register.
REQ-007 branch_taken  input  1  redirect request resolved downstream; 1 = load branch_target and flush IF/ID.
REQ-008 branch_target  input  32  redirect address.
REQ-009 imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-010 imem_addr  output  32  current PC; a combinational copy of the PC register.
REQ-011 if_id_instr  output  32  registered instruction for the decode stage and the hazard unit.
REQ-012 if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-013 if_id_valid  output  1  1 = if_id_instr holds a real fetched instruction.
REQ-014 stall_count  output  CNT_W  number of cycles spent stalled.
REQ-015 flush_count  output  CNT_W  number of redirects taken.

Function
REQ-016 The block SHALL update all state only on the rising edge of CLOCK.
REQ-017 Per-edge priority SHALL be: reset > branch_taken > pc_hold > normal fetch.
REQ-018 Normal fetch (branch_taken=0, pc_hold=0): PC <= PC+4; if_id_instr <= imem_rdata; if_id_pc4 <= PC+4; if_id_valid <= 1.
REQ-019 Hold (branch_taken=0, pc_hold=1): PC, if_id_instr, if_id_pc4 and if_id_valid SHALL keep their values; stall_count SHALL increment.
REQ-020 Redirect (branch_taken=1): PC <= {branch_target[31:2],2'b00}; if_id_instr <= 32'h0 (NOP); if_id_pc4 <= 0; if_id_valid <= 0; flush_count SHALL increment.
REQ-021 A redirect SHALL override a simultaneous pc_hold, and stall_count SHALL NOT increment in that cycle.
REQ-022 PC+4 arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-023 stall_count and flush_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-024 Fetch-to-IF/ID latency SHALL be one cycle: the word read at PC=A SHALL appear on if_id_instr after the next edge.
REQ-025 The block SHALL use no internal state beyond the PC, the IF/ID register and the two counters, and SHALL NOT prefetch.
REQ-026 A bubble (if_id_instr=0) SHALL be indistinguishable from an architectural NOP at the output.

Reset
REQ-027 While RESET_N=0 at an edge: PC <= RESET_PC; if_id_instr <= 0; if_id_pc4 <= 0; if_id_valid <= 0; stall_count <= 0; flush_count <= 0.
REQ-028 Reset SHALL take effect at the edge regardless of pc_hold or branch_taken, including mid-stall and mid-redirect.
REQ-029 On the first edge with RESET_N=1, the block SHALL perform a normal fetch from RESET_PC.

Verification
REQ-030 Reset then 3 free-running edges with imem_rdata=mem[addr>>2] -> imem_addr 0,4,8,12; if_id_instr=mem[0..2]; if_id_pc4 4,8,12; valid=1.
REQ-031 At PC=8, assert pc_hold for 2 edges -> PC stays 8, IF/ID unchanged, stall_count=2; on release, the next edge fetches from 8.
REQ-032 At PC=16, branch_taken=1, branch_target=32'h0000_0103 -> PC=32'h100, if_id_instr=0, valid=0, flush_count=1; the next edge fetches from 32'h100.
REQ-033 branch_taken=1 and pc_hold=1 together, target=32'h40 -> PC=32'h40, flush_count+1, stall_count unchanged.
REQ-034 RESET_PC=32'hFFFF_FFFC, release reset -> first fetch gives if_id_pc4=0 and PC=0; with CNT_W=2, 5 hold cycles -> stall_count=3.
REQ-035 RESET_N=0 during a hold with stall_count=5 -> next edge: all outputs 0 and imem_addr=RESET_PC.
